// File: rtl/systolic_feeder_pkg.sv
// Shared state encodings and width helper for the systolic edge feeder.
package systolic_feeder_pkg;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DONE
  } top_state_t;

  typedef enum logic [2:0] {
    L_IDLE,
    L_SKEW,
    L_SEND,
    L_FIN,
    L_DONE
  } lane_state_t;

  // Bits needed to count 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Load-side and lane-side handshake bundle between a feeder and its neighbours.
interface systolic_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4
);
  logic                        load_valid;
  logic                        load_ready;
  logic [LANES*DATA_WIDTH-1:0] load_data;
  logic                        load_last;
  logic [LANES*DATA_WIDTH-1:0] lane_data;
  logic [LANES-1:0]            lane_waiting;
  logic [LANES-1:0]            lane_finished;
  logic [LANES-1:0]            lane_ready;
  logic                        busy;
  logic                        done;

  modport master (
    output load_valid, load_data, load_last, lane_ready,
    input  load_ready, lane_data, lane_waiting, lane_finished, busy, done
  );

  modport slave (
    input  load_valid, load_data, load_last, lane_ready,
    output load_ready, lane_data, lane_waiting, lane_finished, busy, done
  );
endinterface

// File: rtl/systolic_feeder_lane.sv
// One feeder lane: optional start skew, K element transfers, then a finished beat.
module feeder_lane
  import systolic_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int SKEW       = 0,
  localparam int unsigned CW = cnt_width(DEPTH),
  localparam int unsigned SW = (SKEW > 0) ? $clog2(SKEW + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic [CW-1:0]         k,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] elem,
  output logic [CW-1:0]         rd_idx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  waiting,
  output logic                  finished,
  output logic                  finishing
);

  lane_state_t   state, state_nx;
  logic [CW-1:0] rd_ptr;
  logic [SW-1:0] skew_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= L_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      L_IDLE: if (start) state_nx = (SKEW == 0) ? L_SEND : L_SKEW;
      L_SKEW: if (skew_cnt == '0) state_nx = L_SEND;
      L_SEND: if (ready && (rd_ptr + CW'(1) == k)) state_nx = L_FIN;
      L_FIN:  if (ready) state_nx = L_DONE;
      L_DONE: if (clear) state_nx = L_IDLE;
      default: state_nx = L_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      skew_cnt <= '0;
    end else begin
      if (state == L_IDLE && start) begin
        rd_ptr   <= '0;
        skew_cnt <= SW'((SKEW > 0) ? SKEW - 1 : 0);
      end else begin
        if (state == L_SEND && ready) rd_ptr <= rd_ptr + CW'(1);
        if (state == L_SKEW && skew_cnt != '0) skew_cnt <= skew_cnt - SW'(1);
      end
    end
  end

  always_comb begin
    waiting   = (state == L_SEND);
    finished  = (state == L_FIN);
    data      = waiting ? elem : '0;
    // Lets the top enter DONE in the same cycle the slowest lane reaches L_DONE.
    finishing = (state == L_DONE) || (state == L_FIN && ready);
  end

  assign rd_idx = rd_ptr;

endmodule

// File: rtl/systolic_feeder.sv
// Block buffer plus top LOAD/RUN/DONE control; fans the buffer out to skewed lanes.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int DEPTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  systolic_feeder_if.slave bus
);

  localparam int unsigned CW = cnt_width(DEPTH);

  top_state_t                  state, state_nx;
  logic [CW-1:0]               wr_cnt;
  logic [CW-1:0]               k;
  logic [LANES*DATA_WIDTH-1:0] buf_q [DEPTH];

  logic                        accept;
  logic                        last_beat;
  logic                        all_finishing;
  logic                        load_ready_o, busy_o, done_o;
  logic [LANES*DATA_WIDTH-1:0] lane_data_w;
  logic [LANES-1:0]            waiting_w, finished_w, finishing_w;

  assign accept        = (state == LOAD) && bus.load_valid;
  assign last_beat     = accept && (bus.load_last || wr_cnt == CW'(DEPTH - 1));
  assign all_finishing = &finishing_w;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:    if (last_beat) state_nx = RUN;
      RUN:     if (all_finishing) state_nx = DONE;
      DONE:    state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_comb begin
    load_ready_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (state)
      LOAD:    load_ready_o = 1'b1;
      RUN:     busy_o       = 1'b1;
      DONE:    done_o       = 1'b1;
      default: load_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      k      <= '0;
    end else begin
      if (state == DONE)   wr_cnt <= '0;
      else if (accept)     wr_cnt <= wr_cnt + CW'(1);
      if (last_beat)       k      <= wr_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (wr_cnt == CW'(j)) buf_q[j] <= bus.load_data;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [CW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] elem;

    always_comb begin
      elem = '0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (rd_idx == CW'(j)) elem = buf_q[j][i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    feeder_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .SKEW       (i)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .start     (last_beat),
      .clear     (state == DONE),
      .k         (k),
      .ready     (bus.lane_ready[i]),
      .elem      (elem),
      .rd_idx    (rd_idx),
      .data      (lane_data_w[i*DATA_WIDTH +: DATA_WIDTH]),
      .waiting   (waiting_w[i]),
      .finished  (finished_w[i]),
      .finishing (finishing_w[i])
    );
  end

  assign bus.load_ready    = load_ready_o;
  assign bus.busy          = busy_o;
  assign bus.done          = done_o;
  assign bus.lane_data     = lane_data_w;
  assign bus.lane_waiting  = waiting_w;
  assign bus.lane_finished = finished_w;

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder against a per-lane timeline model.
module tb_systolic_feeder;
  localparam int DW    = 32;
  localparam int LANES = 4;
  localparam int DEPTH = 8;
  localparam int MAXC  = 150;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_feeder_if #(.DATA_WIDTH(DW), .LANES(LANES)) bus ();

  systolic_feeder #(.DATA_WIDTH(DW), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [LANES*DW-1:0] vec      [DEPTH];
  logic [LANES-1:0]    rdy      [MAXC+3];
  logic [LANES-1:0]    exp_wait [MAXC+3];
  logic [LANES-1:0]    exp_fin  [MAXC+3];
  logic [LANES*DW-1:0] exp_data [MAXC+3];
  int                  done_c;

  // Each lane starts i cycles after the block closes, emits its K elements in
  // order (advancing only on ready), then holds finished until ready.
  task automatic build_model(input int k);
    int sent;
    int c;
    done_c = 0;
    for (int n = 0; n < MAXC + 3; n++) begin
      exp_wait[n] = '0;
      exp_fin[n]  = '0;
      exp_data[n] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      sent = 0;
      c    = 1 + i;
      while (c < MAXC) begin
        if (sent < k) begin
          exp_wait[c][i] = 1'b1;
          exp_data[c][i*DW +: DW] = vec[sent][i*DW +: DW];
          if (rdy[c][i]) sent++;
          c++;
        end else begin
          exp_fin[c][i] = 1'b1;
          if (rdy[c][i]) break;
          c++;
        end
      end
      if (c + 1 > done_c) done_c = c + 1;
    end
  endtask

  task automatic fill_rdy(input bit random_mode);
    for (int n = 0; n < MAXC + 3; n++)
      rdy[n] = random_mode ? LANES'($urandom | $urandom) : '1;
  endtask

  task automatic fill_vec_random(input int k);
    for (int b = 0; b < k; b++)
      for (int l = 0; l < LANES; l++) vec[b][l*DW +: DW] = $urandom;
  endtask

  task automatic run_block(input string name, input int k, input bit use_last,
                           input bit hold_valid, input bit gaps, input int abort_c);
    for (int b = 0; b < k; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.load_valid = 1'b0;
        bus.lane_ready = LANES'($urandom);
        @(posedge clk); #1;
      end
      bus.load_valid = 1'b1;
      bus.load_data  = vec[b];
      bus.load_last  = use_last && (b == k - 1);
      bus.lane_ready = LANES'($urandom);
      @(negedge clk);
      checks++;
      if (bus.load_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s load_ready beat %0d: got %b want 1", name, b, bus.load_ready);
      end
      checks++;
      if (bus.lane_waiting !== '0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL %s idle_during_load beat %0d: waiting %b busy %b want 0 0",
                 name, b, bus.lane_waiting, bus.busy);
      end
      @(posedge clk); #1;
    end

    build_model(k);
    if (hold_valid) begin
      bus.load_valid = 1'b1;
      for (int l = 0; l < LANES; l++) bus.load_data[l*DW +: DW] = $urandom;
      bus.load_last = 1'($urandom);
    end else begin
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
    end

    for (int c = 1; c <= done_c + 1; c++) begin
      bus.lane_ready = rdy[c];
      if (c == abort_c) rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.lane_waiting !== exp_wait[c]) begin
        errors++;
        $display("FAIL %s lane_waiting c=%0d: got %b want %b", name, c, bus.lane_waiting, exp_wait[c]);
      end
      checks++;
      if (bus.lane_finished !== exp_fin[c]) begin
        errors++;
        $display("FAIL %s lane_finished c=%0d: got %b want %b", name, c, bus.lane_finished, exp_fin[c]);
      end
      checks++;
      if (bus.lane_data !== exp_data[c]) begin
        errors++;
        $display("FAIL %s lane_data c=%0d: got %h want %h", name, c, bus.lane_data, exp_data[c]);
      end
      checks++;
      if (bus.busy !== (c < done_c) || bus.done !== (c == done_c) ||
          bus.load_ready !== (c > done_c)) begin
        errors++;
        $display("FAIL %s status c=%0d: got busy %b done %b load_ready %b want %b %b %b",
                 name, c, bus.busy, bus.done, bus.load_ready, c < done_c, c == done_c, c > done_c);
      end
      @(posedge clk); #1;
      if (c == done_c) bus.load_valid = 1'b0;
      if (c == abort_c) begin
        rst = 1'b0;
        bus.load_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.lane_waiting !== '0 || bus.lane_finished !== '0 || bus.lane_data !== '0 ||
            bus.load_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL %s after_abort: got wait %b fin %b data %h lr %b busy %b done %b want 0 0 0 1 0 0",
                   name, bus.lane_waiting, bus.lane_finished, bus.lane_data,
                   bus.load_ready, bus.busy, bus.done);
        end
        @(posedge clk); #1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.load_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset status: got lr %b busy %b done %b want 1 0 0", bus.load_ready, bus.busy, bus.done);
    end
    checks++;
    if (bus.lane_waiting !== '0 || bus.lane_finished !== '0 || bus.lane_data !== '0) begin
      errors++;
      $display("FAIL reset lanes: got wait %b fin %b data %h want 0", bus.lane_waiting, bus.lane_finished, bus.lane_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_k3();
    for (int b = 0; b < 3; b++)
      for (int l = 0; l < LANES; l++) vec[b][l*DW +: DW] = DW'(4 * b + l + 1);
    fill_rdy(1'b0);
    run_block("basic_k3", 3, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_full_depth();
    fill_vec_random(DEPTH);
    fill_rdy(1'b0);
    run_block("full_depth", DEPTH, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_lane_stall();
    fill_vec_random(4);
    fill_rdy(1'b0);
    for (int c = 4; c <= 8; c++) rdy[c][2] = 1'b0;
    run_block("lane_stall", 4, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_fin_stall();
    fill_vec_random(3);
    fill_rdy(1'b0);
    for (int c = 5; c <= 7; c++) rdy[c][1] = 1'b0;
    run_block("fin_stall", 3, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_run();
    fill_vec_random(3);
    fill_rdy(1'b0);
    run_block("abort", 3, 1'b1, 1'b0, 1'b0, 2);
    fill_vec_random(1);
    fill_rdy(1'b0);
    run_block("after_abort_k1", 1, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_hold_valid();
    fill_vec_random(5);
    fill_rdy(1'b1);
    run_block("hold_valid", 5, 1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 20; n++) begin
      k = $urandom_range(1, DEPTH);
      fill_vec_random(k);
      fill_rdy(1'b1);
      run_block("random", k, (k < DEPTH) ? 1'b1 : 1'($urandom), 1'($urandom), 1'b1, 0);
    end
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.lane_ready = '0;
    test_reset();
    test_basic_k3();
    test_full_depth();
    test_lane_stall();
    test_fin_stall();
    test_reset_mid_run();
    test_hold_valid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
